host_cmd_loader: RTL and testbench
==================================

// Module: host_cmd_loader
// PURPOSE
//  Host-side command front end sitting directly upstream of the TPU top level.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Decodes weight-tile and input-tile write packets into one-cycle write strobes for weight memory and unified buffer.
//  - Decodes a RUN packet into the one-cycle start pulse the TPU needs, then times the run and flags completion.
// PARAMETERS
//  ADDR_W      13    memory address width (matches base_address)
//  DATA_W      8     element width; one tile = 4 elements
//  RUN_CYCLES  16    cycles from start pulse to done pulse; must be >= 1
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset      in   1          asynchronous, active-high; clears all state
//  in_data    in   DATA_W     command/payload byte
//  in_valid   in   1          in_data valid
//  in_ready   out  1          loader can accept in_data this cycle
//  wm_we      out  1          weight-memory write strobe (1 cycle)
//  ub_we      out  1          unified-buffer write strobe (1 cycle)
//  mem_addr   out  ADDR_W     write address, valid while wm_we/ub_we high
//  wr_data    out  4*DATA_W   tile {e11,e10,e01,e00}; e00 in [DATA_W-1:0]
//  start      out  1          TPU start pulse (1 cycle)
//  busy       out  1          high from RUN accept until done cycle inclusive
//  done       out  1          run-complete pulse (1 cycle)
//  err        out  1          bad-opcode pulse (1 cycle)
// BEHAVIOUR
//  Byte transfer: in_valid & in_ready at a rising edge. Nothing else consumes a byte.
//  Packets:
//   0x01 WR_W, addr_hi, addr_lo, d0..d3
//   0x02 WR_I, addr_hi, addr_lo, d0..d3
//   0x03 RUN
//  Address: mem_addr = {addr_hi[ADDR_W-9:0], addr_lo}; addr_hi upper bits ignored.
//  Data: d0 -> e00, d1 -> e01, d2 -> e10, d3 -> e11.
//  FSM states: OPC, AHI, ALO, DATA(cnt 0..3), WRITE, START, RUN_WAIT.
//   OPC: in_ready=1.
//    0x01/0x02 -> latch target, go AHI.
//    0x03 -> START.
//    Any other byte -> err=1 next cycle, stay OPC. The byte is consumed.
//   AHI -> ALO -> DATA: in_ready=1; advance only on transfer.
//    Stalls (in_valid=0) may occur anywhere inside a packet with no timeout.
//   DATA: after the 4th byte transfer -> WRITE.
//   WRITE: in_ready=0.
//    Exactly one of wm_we/ub_we=1 for this single cycle, with mem_addr/wr_data stable.
//    Then -> OPC.
//   START: in_ready=0, start=1, busy=1 for one cycle.
//    Load counter = RUN_CYCLES-1, then -> RUN_WAIT.
//   RUN_WAIT: in_ready=0, busy=1; counter decrements each cycle.
//    In the cycle counter==0: done=1, then -> OPC.
//    done is therefore exactly RUN_CYCLES cycles after the start cycle.
//  Latency:
//   - Write strobe is the cycle after the last data byte transfer.
//   - start is the cycle after the RUN opcode transfer.
//   - err is the cycle after the bad-opcode transfer.
//  Outputs are registered.
//   - wm_we, ub_we, start, done, err: never high for more than one consecutive cycle.
//   - wm_we and ub_we are never high together.
//   - start and a write strobe are never high together.
//  Reset (async assert, any state):
//   - State -> OPC; counters cleared; partial packet discarded, no write issued.
//   - Outputs: in_ready=1, all strobes/start/busy/done/err = 0, mem_addr = 0, wr_data = 0.
//  Back-to-back: a new opcode is accepted the cycle after WRITE or done; no dead cycle beyond that.
//  Bytes offered while in_ready=0 are held by the host, not dropped.
// TESTING
//  1. Stream 01,00,10,11,22,33,44 with no gaps
//     -> wm_we=1 one cycle after byte 44, mem_addr=0x010, wr_data=0x44332211, ub_we=0.
//  2. 02,1F,FF,01,02,03,04 with in_valid dropped 3 cycles between bytes
//     -> single ub_we, mem_addr=0x1FFF, wr_data=0x04030201.
//  3. 03 with RUN_CYCLES=16
//     -> start at T+1; busy T+1..T+17; done at T+17; in_ready=0 T+1..T+17; next byte accepted T+18.
//  4. 07 then 03
//     -> err pulse once, no write; RUN proceeds normally.
//  5. Assert reset after 01,00,05,AA
//     -> no wm_we/ub_we ever; outputs at reset values; next 01 starts a fresh packet.
//  6. Hold in_valid=1 during RUN_WAIT with 02 on in_data
//     -> not consumed until done+1, then decoded as WR_I.

Source files
------------

// File: rtl/host_cmd_loader.sv
// Host command front end: byte-stream packet decoder for the TPU.
// Issues tile write strobes, the run start pulse, and times the run.
module host_cmd_loader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int RUN_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wm_we,
    output logic                  ub_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [4*DATA_W-1:0]   wr_data,
    output logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    localparam logic [DATA_W-1:0] OP_WR_W = DATA_W'(1);
    localparam logic [DATA_W-1:0] OP_WR_I = DATA_W'(2);
    localparam logic [DATA_W-1:0] OP_RUN  = DATA_W'(3);

    typedef enum logic [2:0] {
        S_OPC,
        S_AHI,
        S_ALO,
        S_DATA,
        S_WRITE,
        S_START,
        S_RUN_WAIT
    } state_t;

    state_t             state;
    logic               tgt_w;
    logic [1:0]         dcnt;
    logic [CNT_W-1:0]   run_cnt;
    logic               xfer;

    assign xfer = in_valid & in_ready;

    // Packet FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_OPC;
            tgt_w    <= 1'b0;
            dcnt     <= '0;
            run_cnt  <= '0;
            in_ready <= 1'b1;
            wm_we    <= 1'b0;
            ub_we    <= 1'b0;
            mem_addr <= '0;
            wr_data  <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Pulse outputs default low so each is a single-cycle strobe.
            wm_we <= 1'b0;
            ub_we <= 1'b0;
            start <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_OPC: begin
                    if (xfer) begin
                        if (in_data == OP_WR_W || in_data == OP_WR_I) begin
                            tgt_w <= (in_data == OP_WR_W);
                            state <= S_AHI;
                        end else if (in_data == OP_RUN) begin
                            state    <= S_START;
                            in_ready <= 1'b0;
                            start    <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_AHI: begin
                    if (xfer) begin
                        // Only the low bits of addr_hi map onto the address.
                        mem_addr[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
                        state <= S_ALO;
                    end
                end
                S_ALO: begin
                    if (xfer) begin
                        mem_addr[7:0] <= in_data[7:0];
                        dcnt  <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        wr_data[dcnt*DATA_W +: DATA_W] <= in_data;
                        dcnt <= dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            state    <= S_WRITE;
                            in_ready <= 1'b0;
                            wm_we    <= tgt_w;
                            ub_we    <= ~tgt_w;
                        end
                    end
                end
                S_WRITE: begin
                    state    <= S_OPC;
                    in_ready <= 1'b1;
                end
                S_START: begin
                    run_cnt <= CNT_W'(RUN_CYCLES - 1);
                    // A one-cycle run completes in the first wait cycle.
                    done    <= (RUN_CYCLES == 1);
                    state   <= S_RUN_WAIT;
                end
                S_RUN_WAIT: begin
                    if (run_cnt == '0) begin
                        state    <= S_OPC;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt - CNT_W'(1);
                        done    <= (run_cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state    <= S_OPC;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_loader.sv
// Directed bench for host_cmd_loader.
// Drives and samples 1 ns after each rising edge.
module tb_host_cmd_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wm_we;
    logic        ub_we;
    logic [12:0] mem_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wm_cnt = 0;
    int ub_cnt = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    int overlap_cnt = 0;
    int mark_wm, mark_ub, mark_err;
    int idx, done_idx;

    host_cmd_loader #(
        .ADDR_W(13),
        .DATA_W(8),
        .RUN_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wm_we(wm_we),
        .ub_we(ub_we),
        .mem_addr(mem_addr),
        .wr_data(wr_data),
        .start(start),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (wm_we) wm_cnt++;
        if (ub_we) ub_cnt++;
        if (err) err_cnt++;
        if (start) start_cnt++;
        if ((wm_we && ub_we) || (start && (wm_we || ub_we))) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and return in the cycle after its transfer.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #2;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {19'd0, mem_addr}, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_strb", {27'd0, wm_we, ub_we, start, done, err}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // 1: weight write, no gaps
        mark_wm = wm_cnt;
        send(8'h01); send(8'h00); send(8'h10);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t1_wm", {31'd0, wm_we}, 32'd1);
        chk("t1_ub", {31'd0, ub_we}, 32'd0);
        chk("t1_addr", {19'd0, mem_addr}, 32'h010);
        chk("t1_data", wr_data, 32'h44332211);
        chk("t1_rdy", {31'd0, in_ready}, 32'd0);
        step();
        chk("t1_wm_off", {31'd0, wm_we}, 32'd0);
        chk("t1_rdy_back", {31'd0, in_ready}, 32'd1);
        chk("t1_wm_once", wm_cnt - mark_wm, 32'd1);

        // 2: input write with 3-cycle gaps
        mark_ub = ub_cnt;
        send(8'h02); repeat (3) step();
        send(8'h1F); repeat (3) step();
        send(8'hFF); repeat (3) step();
        send(8'h01); repeat (3) step();
        send(8'h02); repeat (3) step();
        send(8'h03); repeat (3) step();
        send(8'h04);
        chk("t2_ub", {31'd0, ub_we}, 32'd1);
        chk("t2_wm", {31'd0, wm_we}, 32'd0);
        chk("t2_addr", {19'd0, mem_addr}, 32'h1FFF);
        chk("t2_data", wr_data, 32'h04030201);
        step();
        chk("t2_ub_once", ub_cnt - mark_ub, 32'd1);

        // 3: RUN timing, T+1 is the current cycle after send
        send(8'h03);
        chk("t3_start", {31'd0, start}, 32'd1);
        chk("t3_busy1", {31'd0, busy}, 32'd1);
        chk("t3_rdy1", {31'd0, in_ready}, 32'd0);
        chk("t3_done1", {31'd0, done}, 32'd0);
        for (int k = 2; k <= 17; k++) begin
            step();
            chk("t3_start_off", {31'd0, start}, 32'd0);
            chk("t3_busy", {31'd0, busy}, 32'd1);
            chk("t3_rdy", {31'd0, in_ready}, 32'd0);
            chk("t3_done", {31'd0, done}, {31'd0, k == 17});
        end
        step();
        chk("t3_rdy18", {31'd0, in_ready}, 32'd1);
        chk("t3_busy18", {31'd0, busy}, 32'd0);
        chk("t3_done18", {31'd0, done}, 32'd0);

        // 4: bad opcode then RUN
        mark_err = err_cnt;
        mark_wm  = wm_cnt;
        mark_ub  = ub_cnt;
        send(8'h07);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_rdy", {31'd0, in_ready}, 32'd1);
        send(8'h03);
        chk("t4_err_off", {31'd0, err}, 32'd0);
        chk("t4_start", {31'd0, start}, 32'd1);
        idx = 1;
        while (!done && idx < 40) begin
            step();
            idx++;
        end
        chk("t4_done_at", idx, 32'd17);
        step();
        chk("t4_err_once", err_cnt - mark_err, 32'd1);
        chk("t4_no_wr", (wm_cnt - mark_wm) + (ub_cnt - mark_ub), 32'd0);

        // 5: reset mid-packet
        mark_wm = wm_cnt;
        mark_ub = ub_cnt;
        send(8'h01); send(8'h00); send(8'h05); send(8'hAA);
        reset = 1'b1;
        #2;
        chk("t5_rdy", {31'd0, in_ready}, 32'd1);
        chk("t5_addr", {19'd0, mem_addr}, 32'd0);
        chk("t5_data", wr_data, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("t5_no_wr", (wm_cnt - mark_wm) + (ub_cnt - mark_ub), 32'd0);
        send(8'h01); send(8'h00); send(8'h05);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("t5_wm", {31'd0, wm_we}, 32'd1);
        chk("t5_addr2", {19'd0, mem_addr}, 32'h005);
        chk("t5_data2", wr_data, 32'h44332211);
        step();

        // 6: byte held during RUN_WAIT
        send(8'h03);
        in_data  = 8'h02;
        in_valid = 1'b1;
        idx = 1;
        done_idx = 0;
        while (!in_ready && idx < 40) begin
            if (done) done_idx = idx;
            step();
            idx++;
        end
        chk("t6_accept_at", idx, 32'd18);
        chk("t6_done_at", done_idx, 32'd17);
        step();
        in_valid = 1'b0;
        mark_ub = ub_cnt;
        send(8'h00); send(8'h07);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        chk("t6_ub", {31'd0, ub_we}, 32'd1);
        chk("t6_addr", {19'd0, mem_addr}, 32'h007);
        chk("t6_data", wr_data, 32'hD4C3B2A1);
        step();
        chk("t6_ub_once", ub_cnt - mark_ub, 32'd1);

        chk("start_total", start_cnt, 32'd3);
        chk("no_overlap", overlap_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
